// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the wait-counter sizing helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Bits needed to count 0..max_wait.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational request legality check, store lane formatting and load lane
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_data,
  output logic        req_legal,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // statements leaves it unassigned and infers a latch.
    req_legal = 1'b0;
    if (req_load) begin
      case (req_funct3)
        LB, LBU: req_legal = 1'b1;
        LH, LHU: req_legal = ~req_addr_lo[0];
        LW:      req_legal = (req_addr_lo == 2'b00);
        default: req_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        SB:      req_legal = 1'b1;
        SH:      req_legal = ~req_addr_lo[0];
        SW:      req_legal = (req_addr_lo == 2'b00);
        default: req_legal = 1'b0;
      endcase
    end
  end

  // Replicating the data across lanes lets the memory pick it up from
  // whichever lanes the byte enables select.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_data;
    case (req_funct3[1:0])
      2'd0: begin
        st_be    = 4'b0001 << req_addr_lo;
        st_wdata = {4{req_data[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << req_addr_lo;
        st_wdata = {2{req_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_shifted = rdata >> {ld_addr_lo, 3'b000};
  assign ld_byte      = byte_shifted[7:0];
  assign ld_half      = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data = {24'h0, ld_byte};
      LHU:     ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage request at a time, drives the
// word-addressed data-memory port and returns load data for writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [4:0]  rd_i,
  output logic        hold_en,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CNT_W = cnt_width(MAX_WAIT);

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [CNT_W-1:0] cnt_q;

  logic             req_valid;
  logic             req_legal;
  logic             timeout;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign req_valid = load_en | store_en;

  lsu_align u_align (
    .req_load    (load_en),
    .req_funct3  (funct3),
    .req_addr_lo (mem_addr[1:0]),
    .req_data    (mem_data),
    .req_legal   (req_legal),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_funct3   (funct3_q),
    .ld_addr_lo  (addr_q[1:0]),
    .rdata       (dmem_rdata),
    .ld_data     (ld_data)
  );

  // A response in the last allowed cycle still wins over the timeout.
  assign timeout = (state_q == WAIT) && !dmem_rvalid &&
                   (cnt_q == CNT_W'(MAX_WAIT - 1));

  assign hold_en = rst && (
                     ((state_q == IDLE) && req_valid && req_legal) ||
                     ((state_q == REQ)  && !(dmem_gnt && we_q)) ||
                     ((state_q == WAIT) && !dmem_rvalid && !timeout));

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are cleared too, so every output reads 0
      // while reset is held and an interrupted access leaves nothing behind.
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      cnt_q     <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      lsu_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      wb_en     <= 1'b0;
      lsu_fault <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              addr_q   <= mem_addr;
              wdata_q  <= st_wdata;
              funct3_q <= funct3;
              rd_q     <= rd_i;
              we_q     <= ~load_en;
              be_q     <= load_en ? 4'b1111 : st_be;
              state_q  <= REQ;
            end else begin
              lsu_fault <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            if (we_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= '0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_data <= ld_data;
            wb_rd   <= rd_q;
            wb_en   <= (rd_q != 5'd0);
            state_q <= IDLE;
          end else if (timeout) begin
            wb_data   <= '0;
            wb_rd     <= rd_q;
            wb_en     <= (rd_q != 5'd0);
            lsu_fault <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized transactions
// against a transaction-level model acting as the data memory.
module tb_lsu;

  localparam int MAX_WAIT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic        store_en = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  rd_i = '0;
  logic        hold_en;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .store_en    (store_en),
    .funct3      (funct3),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .rd_i        (rd_i),
    .hold_en     (hold_en),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .lsu_fault   (lsu_fault),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [64];
  logic        exp_wb = 1'b0;
  logic        exp_fault = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_pulses(input string where);
    check({where, ".wb_en"}, wb_en, exp_wb);
    check({where, ".lsu_fault"}, lsu_fault, exp_fault);
  endtask

  // Advance one clock; the pulse outputs are expected high only in the cycle
  // right after a completing edge.
  task automatic tick(input logic wb, input logic flt);
    @(posedge clk);
    #1;
    exp_wb    = wb;
    exp_fault = flt;
  endtask

  function automatic logic legal_ref(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    logic ok_f3;
    size  = int'(f3) % 4;
    ok_f3 = ld ? (f3 != 3'd3 && f3 < 3'd6) : (f3 < 3'd3);
    return ok_f3 && ((addr % (32'd1 << size)) == 0);
  endfunction

  function automatic logic [3:0] be_ref(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (f3 == 3'd0) return 4'(1 << a);
    if (f3 == 3'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_ref(input logic [2:0] f3, input logic [31:0] data);
    if (f3 == 3'd0) return (data & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (data & 32'hFFFF) * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic idle(input int n, input logic force_rv);
    for (int i = 0; i < n; i++) begin
      load_en     = 1'b0;
      store_en    = 1'b0;
      dmem_gnt    = 1'($urandom_range(0, 1));
      dmem_rvalid = force_rv | 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      @(negedge clk);
      check_pulses("idle");
      check("idle.hold", hold_en, 0);
      check("idle.req", dmem_req, 0);
      tick(1'b0, 1'b0);
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // One request from the execute stage, with the bench acting as memory.
  task automatic txn(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                     input int gnt_dly, input int rv_dly, input logic to);
    logic        is_store;
    logic        legal;
    logic        rv;
    logic        last;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_data;
    int          idx;
    is_store = st & ~ld;
    legal    = legal_ref(ld, f3, addr);
    be       = be_ref(f3, addr);
    wd       = wdata_ref(f3, data);
    idx      = int'(addr[7:2]);

    load_en     = ld;
    store_en    = st;
    funct3      = f3;
    mem_addr    = addr;
    mem_data    = data;
    rd_i        = rd;
    dmem_gnt    = 1'($urandom_range(0, 1));
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    @(negedge clk);
    check_pulses("c0");
    check("c0.hold", hold_en, legal);
    check("c0.req", dmem_req, 0);
    if (!legal) begin
      tick(1'b0, 1'b1);
      return;
    end
    tick(1'b0, 1'b0);

    for (int g = 0; g <= gnt_dly; g++) begin
      dmem_gnt    = (g == gnt_dly);
      dmem_rvalid = 1'b0;
      @(negedge clk);
      check_pulses("req");
      check("req.valid", dmem_req, 1);
      check("req.addr", dmem_addr, addr & ~32'h3);
      check("req.we", dmem_we, is_store);
      if (is_store) begin
        check("req.be", dmem_be, be);
        check("req.wdata", dmem_wdata, wd);
      end
      check("req.hold", hold_en, !(g == gnt_dly && is_store));
      tick(1'b0, 1'b0);
    end
    dmem_gnt = 1'b0;

    if (is_store) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] = wd[8*i +: 8];
      return;
    end

    exp_data = to ? 32'h0 : load_ref(f3, addr, mem[idx]);
    for (int k = 0; k < MAX_WAIT; k++) begin
      rv          = !to && (k == rv_dly);
      last        = rv || (to && k == MAX_WAIT - 1);
      dmem_rvalid = rv;
      dmem_rdata  = rv ? mem[idx] : $urandom;
      @(negedge clk);
      check_pulses("wait");
      check("wait.req", dmem_req, 0);
      check("wait.hold", hold_en, !last);
      tick(last && (rd != 5'd0), last && to);
      if (last) begin
        if (rd != 5'd0) begin
          check("wb.data", wb_data, exp_data);
          check("wb.rd", wb_rd, rd);
        end
        break;
      end
    end
    dmem_rvalid = 1'b0;
  endtask

  task automatic reset_mid_wait();
    load_en     = 1'b1;
    store_en    = 1'b0;
    funct3      = 3'd2;
    mem_addr    = 32'h108;
    rd_i        = 5'd9;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    tick(1'b0, 1'b0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    tick(1'b0, 1'b0);
    dmem_gnt = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst.ctrl", {hold_en, wb_en, lsu_fault, dmem_req, dmem_we, dmem_be, wb_rd}, 0);
    check("rst.wb_data", wb_data, 0);
    check("rst.dmem_addr", dmem_addr, 0);
    check("rst.dmem_wdata", dmem_wdata, 0);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    rst     = 1'b1;
    exp_wb    = 1'b0;
    exp_fault = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    @(negedge clk);
    check_pulses("rst.late");
    check("rst.late.hold", hold_en, 0);
    tick(1'b0, 1'b0);
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check_pulses("rst.after");
    check("rst.after.wb_data", wb_data, 0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    int          r;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    // Reset state, with a legal load presented to confirm hold_en stays low.
    load_en  = 1'b1;
    funct3   = 3'd2;
    mem_addr = 32'h100;
    #3;
    check("reset.ctrl", {hold_en, wb_en, lsu_fault, dmem_req, dmem_we, dmem_be, wb_rd}, 0);
    check("reset.wb_data", wb_data, 0);
    check("reset.dmem_addr", dmem_addr, 0);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    rst     = 1'b1;
    idle(2, 1'b0);

    // Fastest aligned LW.
    mem[0] = 32'hDEAD_BEEF;
    txn(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0, 1'b0);
    // Lane extraction on a mixed-sign word, back to back.
    mem[0] = 32'h80FF_1234;
    txn(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd6, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 5'd6, 0, 1, 1'b0);
    txn(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 5'd6, 1, 0, 1'b0);
    // Store formatting.
    txn(1'b0, 1'b1, 3'd0, 32'h201, 32'h0000_00AB, 5'd0, 0, 0, 1'b0);
    txn(1'b0, 1'b1, 3'd1, 32'h202, 32'hCAFE_1234, 5'd0, 2, 0, 1'b0);
    txn(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd3, 0, 0, 1'b0);
    // Illegal requests.
    txn(1'b0, 1'b1, 3'd2, 32'h102, 32'h1111_2222, 5'd0, 0, 0, 1'b0);
    idle(1, 1'b0);
    txn(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 5'd4, 0, 0, 1'b0);
    idle(1, 1'b0);
    // Timeout after a stalled grant, then a late response that must be ignored.
    txn(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 5'd7, 4, 0, 1'b1);
    idle(3, 1'b1);
    // Load into x0 accesses memory but never writes back.
    txn(1'b1, 1'b0, 3'd2, 32'h10C, 32'h0, 5'd0, 0, 2, 1'b0);
    idle(1, 1'b0);
    // Load wins when both requests are raised.
    txn(1'b1, 1'b1, 3'd1, 32'h10E, 32'h5555_5555, 5'd8, 1, 1, 1'b0);
    idle(1, 1'b0);

    reset_mid_wait();

    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom_range(0, 9));
      ld = (r < 5) || (r == 9);
      st = (r >= 5);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld)                   f3 = ($urandom_range(0, 4) < 3) ? 3'($urandom_range(0, 2))
                                                                     : 3'($urandom_range(4, 5));
      else                           f3 = 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      txn(ld, st, f3, addr, $urandom, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          $urandom_range(0, 15) == 0);
      idle(int'($urandom_range(0, 2)), 1'b0);
    end
    idle(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
